lstm_cell_state_ew: RTL and testbench

- Element-wise cell-state update stage of the LSTM cell. It sits directly downstream of the cell control unit's FIFO-read/start_EW path.
- On each start_EW it computes one element of c_t = f*c_prev + i*g, using one shared signed multiplier over two cycles.
- It writes the result into the cell FIFO, which supplies c_prev for the next sequence step, and pulses cell_state_valid back to the control unit.
- It counts elements per sequence step and flags when a full hidden vector has been processed.

---
 rtl/lstm_cell_state_ew.sv | 127 ++++++++++++
 tb/tb_lstm_cell_state_ew.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lstm_cell_state_ew.sv
// LSTM element-wise cell-state update: c_t = f*c_prev + i*g in signed fixed point,
// one shared multiplier over two cycles, saturated result written to the cell FIFO.
module lstm_cell_state_ew #(
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 8,
  parameter int HIDDEN_SIZE = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_EW,
  input  logic [3:0]        seq_idx_control,
  input  logic [DATA_W-1:0] input_gate_data,
  input  logic [DATA_W-1:0] candidate_gate_data,
  input  logic [DATA_W-1:0] forget_gate_data,
  input  logic [DATA_W-1:0] cell_prev_data,
  input  logic              cell_fifo_full,
  output logic [DATA_W-1:0] cell_state_out,
  output logic              cell_state_valid,
  output logic              cell_fifo_wr_en,
  output logic              busy,
  output logic              ew_seq_done,
  output logic              ew_overrun
);

  localparam int PW    = 2*DATA_W - FRAC_W;
  localparam int SW    = PW + 1;
  localparam int CNT_W = $clog2(HIDDEN_SIZE + 1);

  typedef enum logic [2:0] {IDLE, MUL_FC, MUL_IG, ADD_SAT, WRITE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]   i_reg, g_reg, f_reg, cp_reg;
  logic [PW-1:0]       fc_reg, ig_reg;
  logic [DATA_W-1:0]   out_reg;
  logic [CNT_W-1:0]    elem_cnt;
  logic                overrun_reg;

  logic                accept;
  logic                wr;
  logic                last_elem;
  logic [DATA_W-1:0]   mul_a, mul_b;
  logic [2*DATA_W-1:0] prod;
  logic [PW-1:0]       prod_sh;
  logic [FRAC_W-1:0]   unused_prod_frac;
  logic [SW-1:0]       sum;
  logic [SW-DATA_W:0]  sum_top;
  logic [DATA_W-1:0]   sat;

  assign accept    = start_EW && (state == IDLE);
  assign wr        = (state == WRITE) && !cell_fifo_full;
  assign last_elem = (elem_cnt == CNT_W'(HIDDEN_SIZE - 1));

  // One multiplier shared between the f*c_prev and i*g phases
  always_comb begin
    mul_a = i_reg;
    mul_b = g_reg;
    if (state == MUL_FC) begin
      mul_a = f_reg;
      mul_b = cp_reg;
    end
  end

  // Low 2*DATA_W bits of the sign-extended product equal the signed product;
  // dropping the FRAC_W LSBs is the arithmetic shift (floor toward -inf).
  assign prod             = {{DATA_W{mul_a[DATA_W-1]}}, mul_a} * {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
  assign prod_sh          = prod[2*DATA_W-1:FRAC_W];
  assign unused_prod_frac = prod[FRAC_W-1:0];

  assign sum     = {fc_reg[PW-1], fc_reg} + {ig_reg[PW-1], ig_reg};
  assign sum_top = sum[SW-1:DATA_W-1];

  always_comb begin
    sat = sum[DATA_W-1:0];
    if (!((&sum_top) || !(|sum_top))) begin
      sat = sum[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_EW) state_nxt = MUL_FC;
      MUL_FC:  state_nxt = MUL_IG;
      MUL_IG:  state_nxt = ADD_SAT;
      ADD_SAT: state_nxt = WRITE;
      WRITE:   if (!cell_fifo_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      i_reg       <= '0;
      g_reg       <= '0;
      f_reg       <= '0;
      cp_reg      <= '0;
      fc_reg      <= '0;
      ig_reg      <= '0;
      out_reg     <= '0;
      elem_cnt    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        i_reg  <= input_gate_data;
        g_reg  <= candidate_gate_data;
        f_reg  <= forget_gate_data;
        cp_reg <= (seq_idx_control == 4'd0) ? '0 : cell_prev_data;
      end
      if (start_EW && (state != IDLE)) overrun_reg <= 1'b1;
      if (state == MUL_FC)  fc_reg  <= prod_sh;
      if (state == MUL_IG)  ig_reg  <= prod_sh;
      if (state == ADD_SAT) out_reg <= sat;
      if (wr) elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
    end
  end

  assign cell_state_out   = out_reg;
  assign cell_state_valid = wr;
  assign cell_fifo_wr_en  = wr;
  assign busy             = (state != IDLE);
  assign ew_seq_done      = wr && last_elem;
  assign ew_overrun       = overrun_reg;

endmodule

// File: tb/tb_lstm_cell_state_ew.sv
// Scoreboard bench for lstm_cell_state_ew: driver pushes model results, a monitor
// pops and compares on every FIFO write.
module tb_lstm_cell_state_ew;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_EW = 1'b0;
  logic [3:0]  seq_idx_control = '0;
  logic [15:0] input_gate_data = '0, candidate_gate_data = '0;
  logic [15:0] forget_gate_data = '0, cell_prev_data = '0;
  logic        cell_fifo_full = 1'b0;
  logic [15:0] cell_state_out;
  logic        cell_state_valid, cell_fifo_wr_en, busy, ew_seq_done, ew_overrun;

  lstm_cell_state_ew #(.DATA_W(16), .FRAC_W(8), .HIDDEN_SIZE(100)) dut (
    .clk(clk), .rst(rst), .start_EW(start_EW), .seq_idx_control(seq_idx_control),
    .input_gate_data(input_gate_data), .candidate_gate_data(candidate_gate_data),
    .forget_gate_data(forget_gate_data), .cell_prev_data(cell_prev_data),
    .cell_fifo_full(cell_fifo_full), .cell_state_out(cell_state_out),
    .cell_state_valid(cell_state_valid), .cell_fifo_wr_en(cell_fifo_wr_en),
    .busy(busy), .ew_seq_done(ew_seq_done), .ew_overrun(ew_overrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          wcount = 0;
  int          n_done = 0;
  bit          rand_full = 1'b0;
  logic [15:0] sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // c_t = floor(f*c/256) + floor(i*g/256), clamped to 16-bit signed range
  function automatic logic [15:0] model(input logic signed [15:0] f, input logic signed [15:0] c,
                                        input logic signed [15:0] i, input logic signed [15:0] g,
                                        input logic [3:0] s);
    longint cl, fc, ig, sum;
    cl  = (s == 4'd0) ? 0 : longint'(c);
    fc  = (longint'(f) * cl) >>> 8;
    ig  = (longint'(i) * longint'(g)) >>> 8;
    sum = fc + ig;
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (cell_fifo_full) check("no_strobe_when_full", {cell_fifo_wr_en, cell_state_valid}, 0);
      if (cell_fifo_wr_en || cell_state_valid) begin
        check("valid_eq_wr_en", cell_state_valid, cell_fifo_wr_en);
        wcount++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got %0h expected no write", cell_state_out);
        end else begin
          check("cell_state_out", cell_state_out, sbq.pop_front());
        end
        check("ew_seq_done", ew_seq_done, (wcount % 100 == 0));
        if (ew_seq_done) n_done++;
      end else if (ew_seq_done) begin
        check("done_without_write", ew_seq_done, 0);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_full) cell_fifo_full = ($urandom_range(0, 3) == 0);
  end

  task automatic issue(input logic [15:0] f, input logic [15:0] c, input logic [15:0] i,
                       input logic [15:0] g, input logic [3:0] s);
    @(posedge clk); #2;
    forget_gate_data = f; cell_prev_data = c; input_gate_data = i;
    candidate_gate_data = g; seq_idx_control = s; start_EW = 1'b1;
    sbq.push_back(model(f, c, i, g, s));
    @(posedge clk); #2;
    start_EW = 1'b0;
    seq_idx_control = 4'($urandom);
    cell_prev_data = 16'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 80);
    if (busy) check("idle_timeout", busy, 0);
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [15:0] tf[4] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
  logic [15:0] tc[4] = '{16'h7FFF, 16'hFF00, 16'h7F00, 16'h8000};
  logic [15:0] ti[4] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
  logic [15:0] tg[4] = '{16'h0040, 16'hFF80, 16'h7F00, 16'h8000};
  logic [3:0]  ts[4] = '{4'd0, 4'd1, 4'd1, 4'd1};
  logic [15:0] tx[4] = '{16'h0040, 16'hFE80, 16'h7FFF, 16'h8000};

  initial begin
    logic [15:0] hold;
    int w0;

    repeat (2) @(negedge clk);
    check("reset_outputs", {cell_state_out, cell_state_valid, cell_fifo_wr_en, busy, ew_seq_done, ew_overrun}, 0);
    @(posedge clk); #2;
    rst = 1'b1;

    // Basic update with cycle-exact latency
    issue(16'h0080, 16'h0200, 16'h0100, 16'h00C0, 4'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("busy_T+%0d", k), busy, (k <= 4));
      check($sformatf("wr_en_T+%0d", k), cell_fifo_wr_en, (k == 4));
      if (k == 4) check("basic_value", cell_state_out, 16'h01C0);
    end
    wait_idle();

    for (int n = 0; n < 4; n++) begin
      issue(tf[n], tc[n], ti[n], tg[n], ts[n]);
      wait_idle();
      check($sformatf("table_%0d_out", n), cell_state_out, tx[n]);
    end

    // FIFO backpressure: full during cycles T+2..T+7
    w0 = wcount;
    hold = model(16'h0100, 16'h0300, 16'h0080, 16'hFE00, 4'd2);
    issue(16'h0100, 16'h0300, 16'h0080, 16'hFE00, 4'd2);
    @(posedge clk); #2;
    cell_fifo_full = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("bp_wr_T+%0d", k), cell_fifo_wr_en, (k == 8));
      if (k >= 4) check($sformatf("bp_hold_T+%0d", k), cell_state_out, hold);
      if (k == 7) begin
        @(posedge clk); #2;
        cell_fifo_full = 1'b0;
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("bp_single_write", wcount - w0, 1);

    // Overrun: second request at T+2 is ignored
    check("overrun_clear", ew_overrun, 0);
    issue(16'h0180, 16'h0100, 16'h0040, 16'h0200, 4'd3);
    @(posedge clk); #2;
    start_EW = 1'b1;
    forget_gate_data = 16'h7FFF; input_gate_data = 16'h7FFF; candidate_gate_data = 16'h7FFF;
    @(posedge clk); #2;
    start_EW = 1'b0;
    @(negedge clk);
    check("overrun_set", ew_overrun, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("overrun_sticky", ew_overrun, 1);

    // Reset mid-flight at edge T+3
    issue(16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    sbq.delete();
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    wcount = 0;
    n_done = 0;
    @(negedge clk);
    check("midreset_outputs", {cell_state_out, cell_state_valid, cell_fifo_wr_en, busy, ew_seq_done, ew_overrun}, 0);
    repeat (6) @(negedge clk);
    check("midreset_no_write", wcount, 0);

    // Sequence count across the HIDDEN_SIZE boundary
    for (int n = 0; n < 101; n++) begin
      issue(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom_range(1, 15)));
      wait_idle();
    end
    check("seq_done_count", n_done, 1);
    check("seq_write_count", wcount, 101);

    // Randomized with random backpressure
    rand_full = 1'b1;
    for (int n = 0; n < 120; n++) begin
      issue(rand_op(), rand_op(), rand_op(), rand_op(), 4'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_full = 1'b0;
    @(posedge clk); #2;
    cell_fifo_full = 1'b0;
    repeat (10) @(negedge clk);
    check("rand_done_count", n_done, 2);
    check("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
